mem_stage: RTL and testbench

//  LoongArch 5-stage pipeline MEM stage, between EXE and WB.

---
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a five-stage LoongArch pipeline, sitting between EXE and WB.
// It holds one instruction, waits for the data-SRAM response of any load or store
// issued in EXE, and extracts and extends load data. It passes results to WB and
// forwards its pending writeback to ID. Responses that belong to instructions
// flushed by a WB exception or ERTN are counted and dropped.
// Optional build macro: MEM_LOAD_FWD_EN. When defined, load data is forwarded to ID
// from the cycle its response arrives. When undefined, ID stalls on a load in MEM.
module mem_stage #(
  parameter int SIDE_W = 106
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              mem_allowin,
  input  logic              ex_to_mem_valid,
  input  logic [31:0]       ex_pc,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [31:0]       ex_result,
  input  logic [2:0]        ex_ld_op,
  input  logic              ex_mem_req,
  input  logic              ex_has_ex,
  input  logic [SIDE_W-1:0] ex_side,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allowin,
  input  logic              wb_flush,
  output logic              mem_to_wb_valid,
  output logic              mem_to_wb_rf_we,
  output logic [4:0]        mem_to_wb_waddr,
  output logic [31:0]       mem_to_wb_wdata,
  output logic [31:0]       mem_to_wb_pc,
  output logic [SIDE_W-1:0] mem_to_wb_side,
  output logic [38:0]       mem_rf_zip,
  output logic              mem_ex
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_W    = 3'd1;
  localparam logic [2:0] LD_B    = 3'd2;
  localparam logic [2:0] LD_H    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  logic              mem_valid;
  logic [31:0]       pc_r;
  logic              rf_we_r;
  logic [4:0]        waddr_r;
  logic [31:0]       result_r;
  logic [2:0]        ld_op_r;
  logic              mem_req_r;
  logic              has_ex_r;
  logic [SIDE_W-1:0] side_r;

  logic              data_buf_v;
  logic [31:0]       data_buf;
  logic [1:0]        cancel_cnt;

  logic              data_got;
  logic              mem_ready_go;
  logic              mem_leave;
  logic              buf_set;
  logic              blocking;

  logic [1:0]        cancel_inc;
  logic              cancel_dec;
  logic [2:0]        cancel_sum;

  logic [31:0]       ld_raw;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // A response counts for the current instruction only when no stale responses are pending.
  assign data_got     = data_buf_v | (data_sram_data_ok & (cancel_cnt == 2'd0));
  assign mem_ready_go = ~mem_req_r | data_got;
  assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go & ~wb_flush;
  assign mem_leave    = mem_to_wb_valid & wb_allowin;
  assign buf_set      = mem_valid & mem_req_r & data_sram_data_ok & (cancel_cnt == 2'd0)
                        & ~data_buf_v;

  // Stage valid bit: a flush wins over a new instruction arriving from EXE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      mem_valid <= 1'b0;
    end else if (wb_flush) begin
      mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= ex_to_mem_valid;
    end
  end

  // Instruction fields captured from EXE whenever a real instruction is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r      <= '0;
      rf_we_r   <= 1'b0;
      waddr_r   <= '0;
      result_r  <= '0;
      ld_op_r   <= LD_NONE;
      mem_req_r <= 1'b0;
      has_ex_r  <= 1'b0;
      side_r    <= '0;
    end else if (mem_allowin & ex_to_mem_valid & ~wb_flush) begin
      pc_r      <= ex_pc;
      rf_we_r   <= ex_rf_we;
      waddr_r   <= ex_rf_waddr;
      result_r  <= ex_result;
      ld_op_r   <= ex_ld_op;
      mem_req_r <= ex_mem_req;
      has_ex_r  <= ex_has_ex;
      side_r    <= ex_side;
    end
  end

  // Hold a response that arrived while WB was stalled, so the instruction can leave later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_buf_v <= 1'b0;
      data_buf   <= '0;
    end else if (wb_flush | mem_leave) begin
      data_buf_v <= 1'b0;
    end else if (buf_set) begin
      data_buf_v <= 1'b1;
      data_buf   <= data_sram_rdata;
    end
  end

  // Number of responses still owed to flushed instructions; each is dropped on arrival.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cancel_inc = 2'd0;
    if (wb_flush) begin
      cancel_inc = {1'b0, mem_valid & mem_req_r & ~data_got}
                 + {1'b0, ex_to_mem_valid & ex_mem_req};
    end
  end

  assign cancel_dec = data_sram_data_ok & (cancel_cnt != 2'd0);
  assign cancel_sum = {1'b0, cancel_cnt} + {1'b0, cancel_inc} - {2'b00, cancel_dec};

  // Cancel counter update, saturating at 3.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cancel_cnt <= 2'd0;
    end else begin
      cancel_cnt <= cancel_sum[2] ? 2'd3 : cancel_sum[1:0];
    end
  end

  // Select the load byte or halfword from the word and extend it to 32 bits.
  always_comb begin
    ld_raw = data_buf_v ? data_buf : data_sram_rdata;
    case (result_r[1:0])
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = result_r[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_op_r)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_BU:   ld_data = {24'd0, ld_byte};
      LD_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

  assign mem_to_wb_rf_we = rf_we_r;
  assign mem_to_wb_waddr = waddr_r;
  assign mem_to_wb_pc    = pc_r;
  assign mem_to_wb_side  = side_r;
  assign mem_to_wb_wdata = (ld_op_r != LD_NONE) ? ld_data : result_r;
  assign mem_ex          = mem_valid & has_ex_r;

`ifdef MEM_LOAD_FWD_EN
  // ID may consume the load result from the cycle its response arrives.
  assign blocking = mem_valid & (ld_op_r != LD_NONE) & ~data_got;
`else
  // ID stalls on any load in MEM until it reaches WB.
  assign blocking = mem_valid & (ld_op_r != LD_NONE);
`endif

  assign mem_rf_zip = {blocking, mem_valid & rf_we_r & ~has_ex_r, waddr_r, mem_to_wb_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a scoreboard of expected WB transfers plus
// direct checks of stall, buffering, cancel and reset behaviour.
module tb_mem_stage;

  localparam int SIDE_W = 106;

  logic              clk = 1'b0;
  logic              resetn;
  logic              mem_allowin;
  logic              ex_to_mem_valid;
  logic [31:0]       ex_pc;
  logic              ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic [31:0]       ex_result;
  logic [2:0]        ex_ld_op;
  logic              ex_mem_req;
  logic              ex_has_ex;
  logic [SIDE_W-1:0] ex_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              wb_flush;
  logic              mem_to_wb_valid;
  logic              mem_to_wb_rf_we;
  logic [4:0]        mem_to_wb_waddr;
  logic [31:0]       mem_to_wb_wdata;
  logic [31:0]       mem_to_wb_pc;
  logic [SIDE_W-1:0] mem_to_wb_side;
  logic [38:0]       mem_rf_zip;
  logic              mem_ex;

  typedef struct {
    logic [31:0]       pc;
    logic              rf_we;
    logic [4:0]        waddr;
    logic [31:0]       wdata;
    logic [SIDE_W-1:0] side;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_stage #(.SIDE_W(SIDE_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_pc             (ex_pc),
    .ex_rf_we          (ex_rf_we),
    .ex_rf_waddr       (ex_rf_waddr),
    .ex_result         (ex_result),
    .ex_ld_op          (ex_ld_op),
    .ex_mem_req        (ex_mem_req),
    .ex_has_ex         (ex_has_ex),
    .ex_side           (ex_side),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .wb_flush          (wb_flush),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_rf_we   (mem_to_wb_rf_we),
    .mem_to_wb_waddr   (mem_to_wb_waddr),
    .mem_to_wb_wdata   (mem_to_wb_wdata),
    .mem_to_wb_pc      (mem_to_wb_pc),
    .mem_to_wb_side    (mem_to_wb_side),
    .mem_rf_zip        (mem_rf_zip),
    .mem_ex            (mem_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference load extraction, written as shifts of the response word.
  function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = rdata >> (8 * addr);
    h = rdata >> (addr[1] ? 16 : 0);
    case (op)
      3'd2:    return {{24{b[7]}}, b[7:0]};
      3'd3:    return {{16{h[15]}}, h[15:0]};
      3'd4:    return {24'd0, b[7:0]};
      3'd5:    return {16'd0, h[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [SIDE_W-1:0] rnd_side();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[SIDE_W-1:0];
  endfunction

  // WB-side monitor: every accepted transfer must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && mem_to_wb_valid && wb_allowin) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("wb_pc", mem_to_wb_pc, e.pc);
          check("wb_we", mem_to_wb_rf_we, e.rf_we);
          check("wb_waddr", mem_to_wb_waddr, e.waddr);
          check("wb_wdata", mem_to_wb_wdata, e.wdata);
          check("wb_side", mem_to_wb_side, e.side);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from EXE and hold it until MEM accepts it.
  task automatic send(input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr,
                      input logic [31:0] result, input logic [2:0] ld_op, input logic mem_req,
                      input logic has_ex, input logic [SIDE_W-1:0] side, input logic push);
    exp_t e;
    int   n;
    ex_pc = pc; ex_rf_we = rf_we; ex_rf_waddr = waddr; ex_result = result;
    ex_ld_op = ld_op; ex_mem_req = mem_req; ex_has_ex = has_ex; ex_side = side;
    ex_to_mem_valid = 1'b1;
    if (push) begin
      e.pc = pc; e.rf_we = rf_we; e.waddr = waddr; e.side = side; e.wdata = result;
      sb.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!mem_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_allowin) check("send_timeout", 0, 1);
    tick();
    ex_to_mem_valid = 1'b0;
    ex_mem_req      = 1'b0;
    ex_has_ex       = 1'b0;
  endtask

  // Load that completes: checks the stall before the response, then delivers it.
  task automatic do_load(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] addr,
                         input logic [2:0] op, input logic [31:0] rdata, input string tag);
    exp_t e;
    e.pc = pc; e.rf_we = 1'b1; e.waddr = waddr; e.side = rnd_side();
    e.wdata = ld_model(op, addr[1:0], rdata);
    sb.push_back(e);
    send(pc, 1'b1, waddr, addr, op, 1'b1, 1'b0, e.side, 1'b0);
    check({tag, "_stall"}, mem_allowin, 0);
    check({tag, "_blocking"}, mem_rf_zip[38], 1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    check({tag, "_wdata"}, mem_to_wb_wdata, e.wdata);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_data_ok(input logic [31:0] rdata);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    logic [SIDE_W-1:0] s;
    logic [31:0]       v;
    resetn = 1'b0; ex_to_mem_valid = 1'b0; ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    ex_result = '0; ex_ld_op = '0; ex_mem_req = 1'b0; ex_has_ex = 1'b0; ex_side = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allowin = 1'b1; wb_flush = 1'b0;
    tick(); tick();

    // Reset state.
    check("rst_valid", mem_to_wb_valid, 0);
    check("rst_allowin", mem_allowin, 1);
    check("rst_wdata", mem_to_wb_wdata, 0);
    check("rst_pc", mem_to_wb_pc, 0);
    check("rst_zip", mem_rf_zip, 0);
    check("rst_ex", mem_ex, 0);
    check("rst_side", mem_to_wb_side, 0);
    resetn = 1'b1;
    tick();

    // ALU op passes through in one cycle.
    s = rnd_side();
    send(32'h1C00_0000, 1'b1, 5'd3, 32'h1234, 3'd0, 1'b0, 1'b0, s, 1'b1);
    check("alu_valid", mem_to_wb_valid, 1);
    check("alu_wdata", mem_to_wb_wdata, 32'h1234);
    check("alu_allowin", mem_allowin, 1);
    check("alu_zip", mem_rf_zip, {1'b0, 1'b1, 5'd3, 32'h1234});

    // Back-to-back ALU ops.
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      send(32'h1C00_0100 + 32'(4 * i), 1'b1, 5'(i + 8), v, 3'd0, 1'b0, 1'b0, rnd_side(), 1'b1);
    end
    tick();

    // Load extraction patterns.
    do_load(32'h1C00_0200, 5'd4, 32'h0000_1003, 3'd2, 32'h80FF_0000, "ldb");
    do_load(32'h1C00_0204, 5'd5, 32'h0000_1002, 3'd5, 32'h80FF_0000, "ldhu");
    do_load(32'h1C00_0208, 5'd6, 32'h0000_1000, 3'd1, 32'hCAFE_F00D, "ldw");
    do_load(32'h1C00_020C, 5'd7, 32'h0000_1000, 3'd3, 32'h1234_8001, "ldh");
    do_load(32'h1C00_0210, 5'd9, 32'h0000_1001, 3'd4, 32'h0000_9A00, "ldbu");

    // Response arrives while WB is stalled: buffered and released later.
    wb_allowin = 1'b0;
    s = rnd_side();
    send(32'h1C00_0300, 1'b1, 5'd10, 32'h0000_2002, 3'd3, 1'b1, 1'b0, s, 1'b0);
    sb.push_back('{pc: 32'h1C00_0300, rf_we: 1'b1, waddr: 5'd10,
                   wdata: 32'hFFFF_8765, side: s});
    pulse_data_ok(32'h8765_4321);
    data_sram_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      check("buf_valid", mem_to_wb_valid, 1);
      check("buf_wdata", mem_to_wb_wdata, 32'hFFFF_8765);
      check("buf_allowin", mem_allowin, 0);
      tick();
    end
    wb_allowin = 1'b1;
    tick();
    check("buf_release_allowin", mem_allowin, 1);

    // Outstanding load plus EXE request flushed: two stale responses dropped.
    send(32'h1C00_0400, 1'b1, 5'd11, 32'h0000_3000, 3'd1, 1'b1, 1'b0, rnd_side(), 1'b0);
    ex_to_mem_valid = 1'b1; ex_mem_req = 1'b1; ex_ld_op = 3'd1; wb_flush = 1'b1;
    #1;
    check("flush_valid", mem_to_wb_valid, 0);
    tick();
    wb_flush = 1'b0; ex_to_mem_valid = 1'b0; ex_mem_req = 1'b0;
    check("cancel_cnt2", dut.cancel_cnt, 2);
    check("flush_allowin", mem_allowin, 1);
    pulse_data_ok(32'h1111_1111);
    check("cancel_cnt1", dut.cancel_cnt, 1);
    pulse_data_ok(32'h2222_2222);
    check("cancel_cnt0", dut.cancel_cnt, 0);
    do_load(32'h1C00_0404, 5'd12, 32'h0000_3004, 3'd1, 32'h3333_3333, "after_cancel");

    // Response coincident with flush is consumed by the flushed load.
    send(32'h1C00_0500, 1'b1, 5'd13, 32'h0000_4000, 3'd1, 1'b1, 1'b0, rnd_side(), 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_4444; wb_flush = 1'b1;
    #1;
    check("coinc_valid", mem_to_wb_valid, 0);
    tick();
    data_sram_data_ok = 1'b0; wb_flush = 1'b0;
    check("coinc_cnt", dut.cancel_cnt, 0);
    check("coinc_allowin", mem_allowin, 1);
    check("coinc_out", mem_to_wb_valid, 0);

    // Exception-carrying instruction: flagged to EXE, no forwarding write enable.
    send(32'h1C00_0600, 1'b1, 5'd14, 32'h5555, 3'd0, 1'b0, 1'b1, rnd_side(), 1'b1);
    check("exc_mem_ex", mem_ex, 1);
    check("exc_zip_we", mem_rf_zip[37], 0);
    tick();

    // Reset while a load is outstanding.
    send(32'h1C00_0700, 1'b1, 5'd15, 32'h0000_6000, 3'd2, 1'b1, 1'b0, rnd_side(), 1'b0);
    resetn = 1'b0;
    tick();
    check("rst2_valid", mem_to_wb_valid, 0);
    check("rst2_allowin", mem_allowin, 1);
    check("rst2_pc", mem_to_wb_pc, 0);
    check("rst2_zip", mem_rf_zip, 0);
    check("rst2_cnt", dut.cancel_cnt, 0);
    resetn = 1'b1;
    tick(); tick();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
